// File: rtl/sysram_port_arbiter.sv
// sysram_port_arbiter
// Shares the single data-side port of the system RAM between M0 (core LSU)
// and M1 (debug/DMA). Round-robin grant, alignment checking, one outstanding
// read with timeout. Writes and illegal accesses complete in the cycle they
// are granted. Read completions are registered, so a read acks two cycles
// after its request at the earliest.
// Optional build macro: SYSRAM_ARB_LOCK_EN adds the m_lock input, which lets
// a master hold the port across several transactions.
//
// Handshake: a master raises m_req with its command and holds it stable
// until it sees m_ack high at a clock edge; m_err is meaningful only
// together with m_ack, and m_rdata only with a read ack.
module sysram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int RD_TIMEOUT = 15,
    parameter int M0_FIRST   = 1
) (
    input  logic                   hb_clk,
    input  logic                   hb_rst_n,
    input  logic [1:0]             m_req,
    input  logic [1:0]             m_we,
    input  logic [1:0][ADDR_W-1:0] m_addr,
    input  logic [1:0][31:0]       m_wdata,
    input  logic [1:0][1:0]        m_width,
`ifdef SYSRAM_ARB_LOCK_EN
    input  logic [1:0]             m_lock,
`endif
    output logic [1:0]             m_ack,
    output logic [1:0]             m_err,
    output logic [31:0]            m_rdata,
    output logic                   ram_ren,
    output logic                   ram_wen,
    output logic [ADDR_W-1:0]      ram_raddr,
    output logic [ADDR_W-1:0]      ram_waddr,
    output logic [31:0]            ram_wdata,
    output logic [1:0]             ram_width,
    input  logic [31:0]            ram_rdata,
    input  logic                   ram_read_finish,
    input  logic                   ram_write_finish
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [7:0] TMO     = 8'(RD_TIMEOUT);
    localparam logic       PTR_RST = (M0_FIRST != 0) ? 1'b0 : 1'b1;

    logic [1:0] lock_in;
`ifdef SYSRAM_ARB_LOCK_EN
    assign lock_in = m_lock;
`else
    assign lock_in = 2'b00;
`endif

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        lock_q, lock_d;
    logic        lock_own_q, lock_own_d;

    logic [1:0]  elig;
    logic        win;
    logic        illegal;
    logic        lock_act;
    logic        done;
    logic [1:0]  ack_now;
    logic [1:0]  err_now;

    // Arbitration, RAM command generation and next-state computation.
    // A master whose registered read ack is showing this cycle is excluded
    // from arbitration (its request is still high), and immediate acks are
    // held off that cycle so both masters are never acked together.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        ack_d      = 2'b00;
        err_d      = 2'b00;
        rdata_d    = rdata_q;
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        ack_now    = 2'b00;
        err_now    = 2'b00;
        done       = 1'b0;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_raddr  = '0;
        ram_waddr  = '0;
        ram_wdata  = '0;
        ram_width  = '0;

        // While idle the lock survives only as long as its owner keeps m_lock.
        lock_act = lock_q && ((state_q == RD_WAIT) || lock_in[lock_own_q]);
        elig     = m_req & ~ack_q & {2{hb_rst_n}};
        if (lock_act) begin
            elig = elig & (lock_own_q ? 2'b10 : 2'b01);
        end
        win     = elig[ptr_q] ? ptr_q : ~ptr_q;
        illegal = (m_width[win] == 2'd3) ||
                  ((m_width[win] == 2'd1) && m_addr[win][0]) ||
                  ((m_width[win] == 2'd2) && (m_addr[win][1:0] != 2'b00));

        case (state_q)
            IDLE: begin
                lock_d = lock_act;
                if (elig != 2'b00) begin
                    if (!m_we[win] && !illegal) begin
                        ram_ren   = 1'b1;
                        ram_raddr = m_addr[win];
                        owner_d   = win;
                        cnt_d     = '0;
                        state_d   = RD_WAIT;
                        if (lock_in[win]) begin
                            lock_d     = 1'b1;
                            lock_own_d = win;
                        end
                    end else if (ack_q == 2'b00) begin
                        if (illegal) begin
                            ack_now[win] = 1'b1;
                            err_now[win] = 1'b1;
                            done         = 1'b1;
                        end else begin
                            ram_wen   = 1'b1;
                            ram_waddr = m_addr[win];
                            ram_wdata = m_wdata[win];
                            ram_width = m_width[win];
                            if (ram_write_finish) begin
                                ack_now[win] = 1'b1;
                                done         = 1'b1;
                            end
                        end
                        if (done) begin
                            if (lock_in[win]) begin
                                lock_d     = 1'b1;
                                lock_own_d = win;
                            end else begin
                                lock_d = 1'b0;
                                ptr_d  = ~win;
                            end
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (ram_read_finish) begin
                    ack_d[owner_q] = 1'b1;
                    rdata_d        = ram_rdata;
                    state_d        = IDLE;
                    if (lock_in[owner_q]) begin
                        lock_d     = 1'b1;
                        lock_own_d = owner_q;
                    end else begin
                        lock_d = 1'b0;
                        ptr_d  = ~owner_q;
                    end
                end else if (cnt_q + 8'd1 == TMO) begin
                    ack_d[owner_q] = 1'b1;
                    err_d[owner_q] = 1'b1;
                    rdata_d        = '0;
                    state_d        = IDLE;
                    lock_d         = 1'b0;
                    ptr_d          = ~owner_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read completions come from flops; write/illegal completions are immediate.
    assign m_ack   = ack_q | ack_now;
    assign m_err   = err_q | err_now;
    assign m_rdata = rdata_q;

    // State and registered read-completion outputs.
    always_ff @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_RST;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            ack_q      <= 2'b00;
            err_q      <= 2'b00;
            rdata_q    <= '0;
            lock_q     <= 1'b0;
            lock_own_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
        end
    end

endmodule

// File: tb/tb_sysram_port_arbiter.sv
// Directed bench for sysram_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are checked on the falling edge. The RAM read
// side answers one cycle after ram_ren with data 0xA5000000 | address
// unless auto_fin is cleared.
module tb_sysram_port_arbiter;

    logic             hb_clk;
    logic             hb_rst_n;
    logic [1:0]       m_req;
    logic [1:0]       m_we;
    logic [1:0][31:0] m_addr;
    logic [1:0][31:0] m_wdata;
    logic [1:0][1:0]  m_width;
`ifdef SYSRAM_ARB_LOCK_EN
    logic [1:0]       m_lock;
`endif
    logic [1:0]       m_ack;
    logic [1:0]       m_err;
    logic [31:0]      m_rdata;
    logic             ram_ren;
    logic             ram_wen;
    logic [31:0]      ram_raddr;
    logic [31:0]      ram_waddr;
    logic [31:0]      ram_wdata;
    logic [1:0]       ram_width;
    logic [31:0]      ram_rdata;
    logic             ram_read_finish;
    logic             ram_write_finish;

    int   total;
    int   bad;
    logic auto_fin;
    logic ren_l;
    logic [31:0] raddr_l;

    sysram_port_arbiter #(
        .ADDR_W    (32),
        .RD_TIMEOUT(15),
        .M0_FIRST  (1)
    ) dut (
        .hb_clk          (hb_clk),
        .hb_rst_n        (hb_rst_n),
        .m_req           (m_req),
        .m_we            (m_we),
        .m_addr          (m_addr),
        .m_wdata         (m_wdata),
        .m_width         (m_width),
`ifdef SYSRAM_ARB_LOCK_EN
        .m_lock          (m_lock),
`endif
        .m_ack           (m_ack),
        .m_err           (m_err),
        .m_rdata         (m_rdata),
        .ram_ren         (ram_ren),
        .ram_wen         (ram_wen),
        .ram_raddr       (ram_raddr),
        .ram_waddr       (ram_waddr),
        .ram_wdata       (ram_wdata),
        .ram_width       (ram_width),
        .ram_rdata       (ram_rdata),
        .ram_read_finish (ram_read_finish),
        .ram_write_finish(ram_write_finish)
    );

    // clock
    initial hb_clk = 1'b0;
    always #5 hb_clk = ~hb_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // move to the checking point of the current cycle
    task automatic settle();
        @(negedge hb_clk);
    endtask

    // close the current cycle and open the next one; the RAM model answers here
    task automatic advance();
        ren_l   = ram_ren;
        raddr_l = ram_raddr;
        @(posedge hb_clk);
        #1;
        if (auto_fin) begin
            ram_read_finish = ren_l;
            ram_rdata       = ren_l ? (32'hA500_0000 | raddr_l) : 32'h0;
        end
    endtask

    task automatic set_m(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] w);
        m_req[m]   = 1'b1;
        m_we[m]    = we;
        m_addr[m]  = addr;
        m_wdata[m] = wd;
        m_width[m] = w;
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        auto_fin         = 1'b1;
        hb_rst_n         = 1'b0;
        m_req            = '0;
        m_we             = '0;
        m_addr           = '0;
        m_wdata          = '0;
        m_width          = '0;
`ifdef SYSRAM_ARB_LOCK_EN
        m_lock           = '0;
`endif
        ram_rdata        = '0;
        ram_read_finish  = 1'b0;
        ram_write_finish = 1'b1;

        // ---------------- reset state ----------------
        settle();
        chk("rst_ack", m_ack, 2'b00);
        chk("rst_err", m_err, 2'b00);
        chk("rst_rdata", m_rdata, 32'h0);
        chk("rst_ren", ram_ren, 1'b0);
        chk("rst_wen", ram_wen, 1'b0);
        chk("rst_raddr", ram_raddr, 32'h0);
        chk("rst_waddr", ram_waddr, 32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        chk("rst_width", ram_width, 2'd0);
        advance();
        set_m(0, 1'b0, 32'h10, 32'h0, 2'd2);
        settle();
        chk("rst_req_no_ren", ram_ren, 1'b0);
        chk("rst_req_no_ack", m_ack, 2'b00);
        advance();
        hb_rst_n = 1'b1;
        m_req    = '0;
        settle();
        chk("idle_ack", m_ack, 2'b00);

        // ---------------- both masters read ----------------
        advance();
        set_m(0, 1'b0, 32'h10, 32'h0, 2'd2);
        set_m(1, 1'b0, 32'h20, 32'h0, 2'd2);
        settle();
        chk("rd_c0_ren", ram_ren, 1'b1);
        chk("rd_c0_raddr", ram_raddr, 32'h10);
        chk("rd_c0_ack", m_ack, 2'b00);
        advance(); settle();
        chk("rd_c1_ack", m_ack, 2'b00);
        chk("rd_c1_ren", ram_ren, 1'b0);
        advance(); settle();
        chk("rd_c2_ack", m_ack, 2'b01);
        chk("rd_c2_err", m_err, 2'b00);
        chk("rd_c2_rdata", m_rdata, 32'hA500_0010);
        chk("rd_c2_ren_m1", ram_ren, 1'b1);
        chk("rd_c2_raddr_m1", ram_raddr, 32'h20);
        advance();
        m_req[0] = 1'b0;
        settle();
        chk("rd_c3_ack", m_ack, 2'b00);
        advance(); settle();
        chk("rd_c4_ack", m_ack, 2'b10);
        chk("rd_c4_err", m_err, 2'b00);
        chk("rd_c4_rdata", m_rdata, 32'hA500_0020);
        advance();
        m_req = '0;
        settle();
        chk("rd_c5_ack", m_ack, 2'b00);

        // ---------------- M0 streams four word writes ----------------
        for (int i = 0; i < 4; i++) begin
            advance();
            m_req = '0;
            set_m(0, 1'b1, 32'(i * 4), 32'hD000_0000 + 32'(i), 2'd2);
            settle();
            chk("wr_wen", ram_wen, 1'b1);
            chk("wr_waddr", ram_waddr, 32'(i * 4));
            chk("wr_wdata", ram_wdata, 32'hD000_0000 + 32'(i));
            chk("wr_width", ram_width, 2'd2);
            chk("wr_ack", m_ack, 2'b01);
            chk("wr_err", m_err, 2'b00);
        end
        advance();
        m_req = '0;
        settle();
        chk("wr_done_wen", ram_wen, 1'b0);

        // ---------------- write held while RAM not finished ----------------
        advance();
        set_m(1, 1'b1, 32'h40, 32'hCAFE_0001, 2'd2);
        ram_write_finish = 1'b0;
        settle();
        chk("wh_wen", ram_wen, 1'b1);
        chk("wh_waddr", ram_waddr, 32'h40);
        chk("wh_ack", m_ack, 2'b00);
        advance();
        ram_write_finish = 1'b1;
        settle();
        chk("wh_ack2", m_ack, 2'b10);
        chk("wh_wdata", ram_wdata, 32'hCAFE_0001);
        advance();
        m_req = '0;
        settle();

        // ---------------- illegal accesses ----------------
        advance();
        set_m(1, 1'b1, 32'h3, 32'h1111, 2'd1);
        settle();
        chk("ill_half_ack", m_ack, 2'b10);
        chk("ill_half_err", m_err, 2'b10);
        chk("ill_half_wen", ram_wen, 1'b0);
        advance();
        set_m(1, 1'b0, 32'h0, 32'h0, 2'd3);
        settle();
        chk("ill_w3_ack", m_ack, 2'b10);
        chk("ill_w3_err", m_err, 2'b10);
        chk("ill_w3_ren", ram_ren, 1'b0);
        advance();
        m_req = '0;
        set_m(0, 1'b1, 32'h2, 32'h2222, 2'd2);
        settle();
        chk("ill_word_ack", m_ack, 2'b01);
        chk("ill_word_err", m_err, 2'b01);
        chk("ill_word_wen", ram_wen, 1'b0);
        advance();
        set_m(0, 1'b1, 32'h2, 32'hBEEF, 2'd1);
        settle();
        chk("half_ok_ack", m_ack, 2'b01);
        chk("half_ok_err", m_err, 2'b00);
        chk("half_ok_wen", ram_wen, 1'b1);
        chk("half_ok_width", ram_width, 2'd1);
        chk("half_ok_waddr", ram_waddr, 32'h2);
        advance();
        m_req = '0;
        settle();

        // ---------------- read timeout ----------------
        advance();
        auto_fin        = 1'b0;
        ram_read_finish = 1'b0;
        set_m(0, 1'b0, 32'h30, 32'h0, 2'd2);
        settle();
        chk("to_ren", ram_ren, 1'b1);
        chk("to_raddr", ram_raddr, 32'h30);
        for (int k = 1; k <= 15; k++) begin
            advance(); settle();
            chk("to_wait_ack", m_ack, 2'b00);
        end
        advance(); settle();
        chk("to_ack", m_ack, 2'b01);
        chk("to_err", m_err, 2'b01);
        chk("to_rdata", m_rdata, 32'h0);
        advance();
        m_req = '0;
        settle();
        chk("to_c17_ack", m_ack, 2'b00);
        advance(); settle();
        advance(); settle();
        advance();
        ram_read_finish = 1'b1;
        ram_rdata       = 32'h1234_5678;
        settle();
        chk("to_late_ack", m_ack, 2'b00);
        chk("to_late_rdata", m_rdata, 32'h0);
        advance();
        ram_read_finish = 1'b0;
        auto_fin        = 1'b1;
        settle();

        // ---------------- reset in the middle of a read ----------------
        advance();
        set_m(0, 1'b0, 32'h44, 32'h0, 2'd2);
        settle();
        chk("mr_ren", ram_ren, 1'b1);
        advance();
        hb_rst_n = 1'b0;
        m_req    = '0;
        settle();
        chk("mr_rst_ack", m_ack, 2'b00);
        chk("mr_rst_err", m_err, 2'b00);
        chk("mr_rst_ren", ram_ren, 1'b0);
        advance();
        hb_rst_n = 1'b1;
        settle();
        chk("mr_rel_ack", m_ack, 2'b00);
        advance();
        set_m(1, 1'b0, 32'h50, 32'h0, 2'd2);
        settle();
        chk("mr_m1_ren", ram_ren, 1'b1);
        chk("mr_m1_raddr", ram_raddr, 32'h50);
        advance(); settle();
        chk("mr_m1_wait", m_ack, 2'b00);
        advance(); settle();
        chk("mr_m1_ack", m_ack, 2'b10);
        chk("mr_m1_rdata", m_rdata, 32'hA500_0050);
        advance();
        m_req = '0;
        settle();

        // ---------------- fairness with both masters writing ----------------
        advance();
        set_m(0, 1'b1, 32'h80, 32'h8080, 2'd2);
        set_m(1, 1'b1, 32'h90, 32'h9090, 2'd2);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) advance();
            settle();
            chk("fair_ack", m_ack, (j % 2 == 0) ? 2'b01 : 2'b10);
            chk("fair_waddr", ram_waddr, (j % 2 == 0) ? 32'h80 : 32'h90);
        end
        advance();
        m_req = '0;
        settle();
        chk("fair_end_wen", ram_wen, 1'b0);

`ifdef SYSRAM_ARB_LOCK_EN
        // ---------------- M1 locks the port for three reads ----------------
        advance();
        set_m(1, 1'b0, 32'h60, 32'h0, 2'd2);
        m_lock = 2'b10;
        settle();
        chk("lk_ren1", ram_ren, 1'b1);
        chk("lk_raddr1", ram_raddr, 32'h60);
        advance();
        set_m(0, 1'b0, 32'h70, 32'h0, 2'd2);
        settle();
        chk("lk_wait1", m_ack, 2'b00);
        advance(); settle();
        chk("lk_ack1", m_ack, 2'b10);
        chk("lk_m0_blocked", ram_ren, 1'b0);
        advance();
        m_addr[1] = 32'h64;
        settle();
        chk("lk_ren2", ram_ren, 1'b1);
        chk("lk_raddr2", ram_raddr, 32'h64);
        advance(); settle();
        advance(); settle();
        chk("lk_ack2", m_ack, 2'b10);
        advance();
        m_addr[1] = 32'h68;
        settle();
        chk("lk_ren3", ram_ren, 1'b1);
        chk("lk_raddr3", ram_raddr, 32'h68);
        advance(); settle();
        advance(); settle();
        chk("lk_ack3", m_ack, 2'b10);
        chk("lk_rdata3", m_rdata, 32'hA500_0068);
        advance();
        m_req[1] = 1'b0;
        m_lock   = 2'b00;
        settle();
        chk("lk_m0_ren", ram_ren, 1'b1);
        chk("lk_m0_raddr", ram_raddr, 32'h70);
        advance(); settle();
        advance(); settle();
        chk("lk_m0_ack", m_ack, 2'b01);
        chk("lk_m0_rdata", m_rdata, 32'hA500_0070);
        advance();
        m_req = '0;
        settle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
